vga_box_renderer: RTL and testbench



---
 rtl/vga_pkg.sv | 12 +
 rtl/box_axis_mover.sv | 55 +++++
 rtl/vga_box_renderer.sv | 88 ++++++++
 tb/tb_vga_box_renderer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions used by the timing driver and the pixel stages.
package vga_pkg;
  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned V_ACTIVE   = 480;
  localparam int unsigned TOTAL_COLS = 800;
  localparam int unsigned TOTAL_ROWS = 525;
  localparam int unsigned RGB_W      = 4;
  localparam int unsigned POS_W      = 11;

  typedef logic [3*RGB_W-1:0] rgb444_t;
  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;
endpackage

// File: rtl/box_axis_mover.sv
// One axis of the bouncing box: steps once per enabled tick, clamps and reverses at the edges.
module box_axis_mover
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned SIZE   = 32,
  parameter int unsigned STEP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  output logic [POS_W-1:0] pos,
  output dir_e             dir
);
  localparam logic [POS_W-1:0] MAX    = POS_W'(ACTIVE - SIZE);
  localparam logic [POS_W-1:0] STEP_W = POS_W'(STEP);

  logic [POS_W-1:0] pos_q, pos_d;
  dir_e             dir_q, dir_d;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick_en) begin
      if (dir_q == DIR_POS) begin
        if (pos_q + STEP_W >= MAX) begin
          pos_d = MAX;
          dir_d = DIR_NEG;
        end else begin
          pos_d = pos_q + STEP_W;
        end
      end else begin
        if (pos_q <= STEP_W) begin
          pos_d = '0;
          dir_d = DIR_POS;
        end else begin
          pos_d = pos_q - STEP_W;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      dir_q <= DIR_POS;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;
endmodule

// File: rtl/vga_box_renderer.sv
// Pixel stage after the VGA timing driver: draws a bouncing square, 2-cycle pipeline with delayed syncs.
module vga_box_renderer
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int unsigned BOX_SIZE  = 32,
  parameter int unsigned STEP      = 2,
  parameter logic [11:0] BOX_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR  = 12'h008
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       blanking,
  input  logic       HSync,
  input  logic       VSync,
  input  logic       pause,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       frame_tick
);
  logic [POS_W-1:0] box_x, box_y;
  dir_e             dir_x, dir_y;
  logic             unused_dir;
  logic             vsync_prev_q, frame_tick_q, tick_en;
  logic             hit_q, hit_d, blank_q, hs_d1_q, vs_d1_q, hs_q, vs_q;
  rgb444_t          rgb_q, rgb_d;
  logic [POS_W-1:0] px, py;

  assign unused_dir = ^{dir_x, dir_y};
  assign tick_en    = frame_tick_q & ~pause;

  box_axis_mover #(.ACTIVE(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP)) u_mover_x (
    .clk(clk), .rst(rst), .tick_en(tick_en), .pos(box_x), .dir(dir_x)
  );

  box_axis_mover #(.ACTIVE(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP)) u_mover_y (
    .clk(clk), .rst(rst), .tick_en(tick_en), .pos(box_y), .dir(dir_y)
  );

  assign px = POS_W'(x);
  assign py = POS_W'(y);

  always_comb begin
    hit_d = (px >= box_x) && (px < box_x + POS_W'(BOX_SIZE)) &&
            (py >= box_y) && (py < box_y + POS_W'(BOX_SIZE));
    rgb_d = BG_COLOR;
    if (blank_q)    rgb_d = '0;
    else if (hit_q) rgb_d = BOX_COLOR;
  end

  // Stage-1 blank resets high so the first refilled pixel after reset is black.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev_q <= 1'b1;
      frame_tick_q <= 1'b0;
      hit_q        <= 1'b0;
      blank_q      <= 1'b1;
      hs_d1_q      <= 1'b1;
      vs_d1_q      <= 1'b1;
      rgb_q        <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
    end else begin
      vsync_prev_q <= VSync;
      frame_tick_q <= vsync_prev_q & ~VSync;
      hit_q        <= hit_d;
      blank_q      <= blanking;
      hs_d1_q      <= HSync;
      vs_d1_q      <= VSync;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d1_q;
      vs_q         <= vs_d1_q;
    end
  end

  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];
  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_box_renderer.sv
// Randomized bench for vga_box_renderer against a rectangle/bounce reference model.
module tb_vga_box_renderer;
  localparam int HA = 78;
  localparam int VA = 47;
  localparam int BS = 16;
  localparam int ST = 3;
  localparam int MAXX = HA - BS;
  localparam int MAXY = VA - BS;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x;
  logic [8:0] y;
  logic       blanking, HSync, VSync, pause;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, frame_tick;

  int total = 0;
  int bad = 0;
  int n_ticks = 0;

  // reference model state
  int  m_bx, m_by, m_dx, m_dy;
  bit  m_tick;
  bit  p_blank, p_hs, p_vs, p_hit;

  always #5 clk = ~clk;

  vga_box_renderer #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .BOX_SIZE(BS), .STEP(ST),
    .BOX_COLOR(12'hF00), .BG_COLOR(12'h008)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .blanking(blanking),
    .HSync(HSync), .VSync(VSync), .pause(pause),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_tick(frame_tick)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  function automatic void bounce(inout int p, inout int d, input int mx);
    if (d > 0) begin
      if (p + ST >= mx) begin p = mx; d = -1; end
      else p = p + ST;
    end else begin
      if (p <= ST) begin p = 0; d = 1; end
      else p = p - ST;
    end
  endfunction

  function automatic void model_reset();
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    m_tick = 0;
    p_blank = 1; p_hs = 1; p_vs = 1; p_hit = 0;
  endfunction

  // Compare process: predicts outputs after each edge from the inputs seen before it.
  always @(posedge clk) begin
    int exp_rgb, exp_hs, exp_vs, exp_tick;
    bit cur_hit;
    if (rst) begin
      model_reset();
      #1;
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
      chk("rst_hs", vga_hs, 1);
      chk("rst_vs", vga_vs, 1);
      chk("rst_tick", frame_tick, 0);
    end else begin
      cur_hit = (int'(x) >= m_bx) && (int'(x) < m_bx + BS) &&
                (int'(y) >= m_by) && (int'(y) < m_by + BS);
      exp_rgb  = p_blank ? 0 : (p_hit ? 12'hF00 : 12'h008);
      exp_hs   = p_hs;
      exp_vs   = p_vs;
      exp_tick = (p_vs && !VSync) ? 1 : 0;
      if (m_tick && !pause) begin
        bounce(m_bx, m_dx, MAXX);
        bounce(m_by, m_dy, MAXY);
      end
      m_tick  = exp_tick[0];
      p_blank = blanking; p_hs = HSync; p_vs = VSync; p_hit = cur_hit;
      #1;
      chk("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
      chk("hs", vga_hs, exp_hs);
      chk("vs", vga_vs, exp_vs);
      chk("tick", frame_tick, exp_tick);
      if (frame_tick) n_ticks++;
    end
  end

  task automatic lit_pixel(input string name, input int px, input int py, input bit bl, input int exp);
    @(negedge clk);
    x = 10'(px); y = 9'(py); blanking = bl; VSync = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk(name, {vga_r, vga_g, vga_b}, exp);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic rnd_pix();
    bit near;
    near = ($urandom_range(0, 1) == 1);
    if (near) begin
      x = 10'(clampi(m_bx + int'($urandom_range(0, BS + 3)) - 2, 0, HA - 1));
      y = 9'(clampi(m_by + int'($urandom_range(0, BS + 3)) - 2, 0, VA - 1));
    end else begin
      x = 10'($urandom_range(0, HA - 1));
      y = 9'($urandom_range(0, VA - 1));
    end
    blanking = ($urandom_range(0, 4) == 0);
    if (blanking && $urandom_range(0, 1) == 1) begin
      x = '0; y = 9'd479;
    end
  endtask

  task automatic run_frame(input int len, input bit pz);
    @(negedge clk);
    pause = pz;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      VSync = !(i >= 2 && i < 5);
      HSync = !((i % 9) == 6 || (i % 9) == 7);
      rnd_pix();
    end
  endtask

  initial begin
    int t0;
    rst = 1'b1; x = '0; y = 9'd479; blanking = 1'b1;
    HSync = 1'b1; VSync = 1'b1; pause = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // box at (0,0)
    lit_pixel("box_in", 10, 10, 0, 12'hF00);
    lit_pixel("bg_right", 40, 10, 0, 12'h008);
    lit_pixel("box_corner", 15, 15, 0, 12'hF00);
    lit_pixel("bg_edge_x", 16, 0, 0, 12'h008);
    lit_pixel("bg_edge_y", 0, 16, 0, 12'h008);
    lit_pixel("blank_in_box", 5, 5, 1, 0);

    // one unpaused frame moves the box to (3,3)
    run_frame(20, 0);
    lit_pixel("mv_bg", 2, 2, 0, 12'h008);
    lit_pixel("mv_box_lo", 3, 3, 0, 12'hF00);
    lit_pixel("mv_box_hi", 18, 18, 0, 12'hF00);
    lit_pixel("mv_bg_hi", 19, 3, 0, 12'h008);

    // paused frames: ticks continue, box frozen
    t0 = n_ticks;
    for (int i = 0; i < 3; i++) run_frame(20, 1);
    chk("pause_ticks", n_ticks - t0, 3);
    lit_pixel("pause_box", 3, 3, 0, 12'hF00);
    lit_pixel("pause_bg", 2, 2, 0, 12'h008);

    for (int i = 0; i < 220; i++)
      run_frame(int'($urandom_range(14, 40)), ($urandom_range(0, 7) == 0));

    // asynchronous reset mid-line
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("async_hs", vga_hs, 1);
    chk("async_vs", vga_vs, 1);
    chk("async_tick", frame_tick, 0);
    repeat (2) @(negedge clk);
    VSync = 1'b1; HSync = 1'b1;
    rst = 1'b0;
    lit_pixel("post_rst_box", 0, 0, 0, 12'hF00);
    lit_pixel("post_rst_bg", 16, 16, 0, 12'h008);

    for (int i = 0; i < 60; i++)
      run_frame(int'($urandom_range(14, 40)), ($urandom_range(0, 7) == 0));

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
